// File: rtl/reg_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_pkg
// Description : Shared types and default sizes for the register dump
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_dump_pkg;

    localparam int c_DATA_W = 24;   // default register data width
    localparam int c_ADDR_W = 4;    // default register index width
    localparam int NUM_REGS = 16;   // registers addressable with c_ADDR_W bits

    // Controller states; one word takes ISSUE -> WAIT -> PRESENT.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_PRESENT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/reg_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_ctrl
// Description : Walks a register file from first_idx to last_idx (wrapping
//               modulo the register count), reads each register through a
//               one-cycle-latency read port and streams the values out on a
//               valid/ready interface. Supports abort and reports done.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_dump_ctrl
    import reg_dump_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_idx,
    input  logic [ADDR_W-1:0] last_idx,
    output logic [ADDR_W-1:0] regselector,
    input  logic [DATA_W-1:0] rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_index,
    output logic              dump_last,
    output logic              busy,
    output logic              done
);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_cur_idx;
    logic [ADDR_W-1:0]   r_last_idx;
    logic [DATA_W-1:0]   r_dump_data;
    logic [ADDR_W-1:0]   r_dump_index;
    logic                w_at_last;

    // The first index needs no separate copy: cur_idx is loaded with it at
    // start and is the only place it is ever used.
    assign w_at_last = (r_cur_idx == r_last_idx);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort in any active state wins over everything else.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_ISSUE;
            S_ISSUE:   w_next = S_WAIT;
            S_WAIT:    w_next = S_PRESENT;
            S_PRESENT: begin
                if (dump_ready) begin
                    w_next = w_at_last ? S_DONE : S_ISSUE;
                end
            end
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        if (abort && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end
    end

    // Index bookkeeping and capture of the read data at the end of WAIT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cur_idx    <= '0;
            r_last_idx   <= '0;
            r_dump_data  <= '0;
            r_dump_index <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_cur_idx  <= first_idx;
                r_last_idx <= last_idx;
            end
            if (r_state == S_WAIT) begin
                r_dump_data  <= rdata;
                r_dump_index <= r_cur_idx;
            end
            // Natural overflow of the index gives the 15 -> 0 wrap.
            if ((r_state == S_PRESENT) && dump_ready && !abort && !w_at_last) begin
                r_cur_idx <= r_cur_idx + ADDR_W'(1);
            end
        end
    end

    // The read select is the current index; it is stable from ISSUE through
    // WAIT, which is all the register file needs.
    assign regselector = r_cur_idx;
    assign dump_data   = r_dump_data;
    assign dump_index  = r_dump_index;
    assign dump_valid  = (r_state == S_PRESENT);
    assign dump_last   = (r_state == S_PRESENT) && w_at_last;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_dump_ctrl
// Description : Self-checking bench for reg_dump_ctrl with a behavioural
//               register file and a word-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_dump_ctrl;
    import reg_dump_pkg::*;

    localparam int DW = 24;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [AW-1:0] first_idx;
    logic [AW-1:0] last_idx;
    logic [AW-1:0] regselector;
    logic [DW-1:0] rdata;
    logic          dump_valid;
    logic          dump_ready;
    logic [DW-1:0] dump_data;
    logic [AW-1:0] dump_index;
    logic          dump_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [NUM_REGS];

    int tests = 0;
    int fails = 0;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } word_t;

    word_t expq[$];

    always #5 clk = ~clk;

    // Register file: synchronous read, data valid one clock after the select.
    always @(posedge clk) rdata <= mem[regselector];

    reg_dump_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .first_idx   (first_idx),
        .last_idx    (last_idx),
        .regselector (regselector),
        .rdata       (rdata),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_data   (dump_data),
        .dump_index  (dump_index),
        .dump_last   (dump_last),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected word list: indices first, first+1, ... last modulo 16.
    function automatic void build_model(input int f, input int l);
        int cnt;
        word_t w;
        expq.delete();
        cnt = (((l - f) % NUM_REGS) + NUM_REGS) % NUM_REGS + 1;
        for (int k = 0; k < cnt; k++) begin
            w.idx  = (f + k) % NUM_REGS;
            w.data = mem[w.idx];
            expq.push_back(w);
        end
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_regselector"}, regselector, 0);
        check({tag, "_dump_data"},   dump_data,   0);
        check({tag, "_dump_index"},  dump_index,  0);
        check({tag, "_dump_valid"},  dump_valid,  0);
        check({tag, "_dump_last"},   dump_last,   0);
        check({tag, "_busy"},        busy,        0);
        check({tag, "_done"},        done,        0);
    endtask

    // Runs one dump from a negedge. stall_word < 0 means no stall,
    // abort_word < 0 means no abort. noise keeps start high with random
    // indices while busy; abort_at_start raises abort together with start.
    task automatic run_dump(input int f, input int l, input int stall_word, input int stall_len,
                            input int abort_word, input bit noise, input bit abort_at_start);
        int  total;
        int  word;
        int  stalled;
        int  exp_done;
        bit  got_valid;
        build_model(f, l);
        total     = expq.size();
        word      = 0;
        stalled   = 0;
        got_valid = 0;
        exp_done  = 3 * total + 1 + (((stall_word >= 0) && (stall_word < total)) ? stall_len : 0);
        start      = 1'b1;
        abort      = abort_at_start;
        first_idx  = AW'(f);
        last_idx   = AW'(l);
        dump_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = noise;
        for (int n = 1; n <= 200; n++) begin
            check("busy_active", busy, 1);
            if (dump_valid) begin
                if (!got_valid) begin
                    check("first_valid_cycle", n, 3);
                    got_valid = 1;
                end
                if (expq.size() == 0) begin
                    check("valid_past_last_word", dump_valid, 0);
                end else begin
                    check("dump_index", dump_index, expq[0].idx);
                    check("dump_data",  dump_data,  expq[0].data);
                    check("dump_last",  dump_last,  (expq.size() == 1) ? 1 : 0);
                end
                if (word == abort_word) begin
                    abort      = 1'b1;
                    dump_ready = 1'b1;
                    start      = 1'b0;
                    @(negedge clk);
                    abort = 1'b0;
                    check("abort_busy",  busy,       0);
                    check("abort_valid", dump_valid, 0);
                    check("abort_done",  done,       0);
                    @(negedge clk);
                    check("abort_no_late_done", done, 0);
                    check("abort_stays_idle",   busy, 0);
                    return;
                end
                if ((word == stall_word) && (stalled < stall_len)) begin
                    dump_ready = 1'b0;
                    stalled++;
                end else begin
                    dump_ready = 1'b1;
                    if (expq.size() > 0) void'(expq.pop_front());
                    word++;
                end
            end else begin
                check("last_low_without_valid", dump_last, 0);
            end
            if (done) begin
                check("done_word_count", word, total);
                check("done_cycle", n, exp_done);
                start = 1'b0;
                @(negedge clk);
                check("done_single_pulse", done, 0);
                check("idle_after_done",   busy, 0);
                return;
            end
            if (noise) begin
                start     = 1'b1;
                first_idx = AW'($urandom);
                last_idx  = AW'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("dump_timeout_done", done, 1);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NUM_REGS; i++) mem[i] = DW'($urandom);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        dump_ready = 1'b1;
        first_idx  = '0;
        last_idx   = '0;
        for (int i = 0; i < NUM_REGS; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        // Abort while idle does nothing.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_ignored", busy, 0);

        // Full dump with a recognisable pattern.
        for (int i = 0; i < NUM_REGS; i++) mem[i] = DW'(i * 'h111111);
        run_dump(0, 15, -1, 0, -1, 0, 0);

        // Wrap-around range.
        fill_random();
        run_dump(14, 1, -1, 0, -1, 0, 0);

        // Backpressure on the second word, start noise while busy.
        fill_random();
        run_dump(3, 8, 1, 5, -1, 1, 0);

        // Single word; abort together with start in IDLE still starts.
        fill_random();
        run_dump(7, 7, -1, 0, -1, 0, 1);

        // Abort during the third word, then a normal dump.
        fill_random();
        run_dump(0, 9, -1, 0, 2, 0, 0);
        run_dump(5, 10, -1, 0, -1, 0, 0);

        // Randomized dumps.
        for (int r = 0; r < 6; r++) begin
            fill_random();
            run_dump(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                     -1, bit'($urandom_range(0, 1)), 1'b0);
        end

        // Reset during WAIT of the first word.
        fill_random();
        start     = 1'b1;
        first_idx = AW'(9);
        last_idx  = AW'(12);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_reset_busy", busy, 1);
        reset = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        fill_random();
        run_dump(12, 2, 0, 2, -1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
